// File: rtl/cs_pkg.sv
// Shared types and constants for the CS window/approximation sequencer.
// Window depth 9, X 8 bits, Y 10 bits, window slot index 4 bits.
package cs_pkg;

   localparam int unsigned CS_WIN   = 9;
   localparam int unsigned CS_X_W   = 8;
   localparam int unsigned CS_Y_W   = 10;
   localparam int unsigned CS_IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      RUN
   } cs_state_e;

endpackage

// File: rtl/cs_valid_pipe.sv
// Stall-able valid shift register that tracks compute issues through the datapath.
// Holds its contents while i_en=0; i_clr empties it like reset does.
module cs_valid_pipe #(
   parameter int unsigned DEPTH = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   input  logic i_din,
   output logic o_dout
);

   logic [DEPTH-1:0] r_pipe;
   logic [DEPTH-1:0] w_next;

   generate
      if (DEPTH == 1) begin : g_one
         assign w_next = i_din;
      end else begin : g_shift
         assign w_next = {r_pipe[DEPTH-2:0], i_din};
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_pipe <= '0;
      end else if (i_en) begin
         r_pipe <= w_next;
      end
   end

   assign o_dout = r_pipe[DEPTH-1];

endmodule

// File: rtl/cs_window_ctrl.sv
// Sequencer for the CS 9-sample window datapath: X handshake, window slot/fill tracking,
// compute gating, Y validity and delivered-output count. `CS_FLUSH_EN adds the flush port.
module cs_window_ctrl
   import cs_pkg::*;
#(
   parameter int unsigned WIN    = CS_WIN,
   parameter int unsigned DP_LAT = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                dp_wr_en,
   output logic [CS_IDX_W-1:0] dp_wr_idx,
   output logic                dp_compute,
   output logic                dp_stall,
   output logic                win_full,
`ifdef CS_FLUSH_EN
   input  logic                flush,
`endif
   output logic [CNT_W-1:0]    out_cnt
);

   localparam int unsigned          FILL_W       = $clog2(WIN + 1);
   localparam logic [CS_IDX_W-1:0]  LP_PTR_LAST  = CS_IDX_W'(WIN - 1);
   localparam logic [FILL_W-1:0]    LP_FILL_LAST = FILL_W'(WIN - 1);
   localparam logic [FILL_W-1:0]    LP_FILL_MAX  = FILL_W'(WIN);

   cs_state_e           r_state;
   cs_state_e           w_state_nxt;
   logic [CS_IDX_W-1:0] r_wr_ptr;
   logic [FILL_W-1:0]   r_fill_cnt;
   logic [CNT_W-1:0]    r_out_cnt;
   logic                w_flush;
   logic                w_stall;
   logic                w_accept;
   logic                w_issue;
   logic                w_pipe_en;
   logic                w_out_valid;

`ifdef CS_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   // Backpressure freezes the whole datapath; reset and flush both block new samples.
   assign w_stall   = w_out_valid & ~out_ready;
   assign in_ready  = ~reset & ~w_stall & ~w_flush;
   assign dp_stall  = ~reset & w_stall;
   assign w_accept  = in_valid & in_ready;
   assign w_issue   = w_accept & (r_fill_cnt >= LP_FILL_LAST);
   assign w_pipe_en = ~w_stall;

   assign dp_wr_en   = w_accept;
   assign dp_wr_idx  = r_wr_ptr;
   assign dp_compute = w_issue;
   assign out_valid  = w_out_valid;
   assign out_cnt    = r_out_cnt;

   always_ff @(posedge clk) begin
      if (reset || w_flush) begin
         r_wr_ptr   <= '0;
         r_fill_cnt <= '0;
      end else if (w_accept) begin
         r_wr_ptr <= (r_wr_ptr == LP_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
         if (r_fill_cnt != LP_FILL_MAX) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_cnt <= '0;
      end else if (w_out_valid && out_ready) begin
         r_out_cnt <= r_out_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_flush) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_accept) w_state_nxt = FILL;
            FILL:    if (w_accept && (r_fill_cnt == LP_FILL_LAST)) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      win_full = (r_state == RUN);
   end

   cs_valid_pipe #(
      .DEPTH(DP_LAT)
   ) u_valid_pipe (
      .i_clk (clk),
      .i_rst (reset),
      .i_clr (w_flush),
      .i_en  (w_pipe_en),
      .i_din (w_issue),
      .o_dout(w_out_valid)
   );

endmodule

// File: tb/tb_cs_window_ctrl.sv
// Directed bench for cs_window_ctrl: DP_LAT=1 instance for sequencing/stall/reset,
// DP_LAT=3 / CNT_W=4 instance for latency, counter wrap and (with CS_FLUSH_EN) flush.
module tb_cs_window_ctrl;
   import cs_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_reset, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic        a_dp_wr_en, a_dp_compute, a_dp_stall, a_win_full;
   logic [3:0]  a_dp_wr_idx;
   logic [15:0] a_out_cnt;

   logic        b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic        b_dp_wr_en, b_dp_compute, b_dp_stall, b_win_full;
   logic [3:0]  b_dp_wr_idx;
   logic [3:0]  b_out_cnt;

`ifdef CS_FLUSH_EN
   logic a_flush = 1'b0;
   logic b_flush = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int n_issue  = 0;

   cs_window_ctrl #(.WIN(9), .DP_LAT(1), .CNT_W(16)) u_dut (
      .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .dp_wr_en(a_dp_wr_en),
      .dp_wr_idx(a_dp_wr_idx), .dp_compute(a_dp_compute), .dp_stall(a_dp_stall),
      .win_full(a_win_full),
`ifdef CS_FLUSH_EN
      .flush(a_flush),
`endif
      .out_cnt(a_out_cnt)
   );

   cs_window_ctrl #(.WIN(9), .DP_LAT(3), .CNT_W(4)) u_dut3 (
      .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .dp_wr_en(b_dp_wr_en),
      .dp_wr_idx(b_dp_wr_idx), .dp_compute(b_dp_compute), .dp_stall(b_dp_stall),
      .win_full(b_win_full),
`ifdef CS_FLUSH_EN
      .flush(b_flush),
`endif
      .out_cnt(b_out_cnt)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a_reset = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1;
      b_reset = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b1;
      #1;
      n_checks++;
      if ({a_in_ready, a_dp_wr_en, a_dp_compute, a_dp_stall} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_comb: got %b want 0000", {a_in_ready, a_dp_wr_en, a_dp_compute, a_dp_stall});
      end
      cyc(); cyc();
      n_checks++;
      if ({a_out_valid, a_dp_wr_idx, a_win_full} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_regs: got ov=%b idx=%0d wf=%b want 0/0/0", a_out_valid, a_dp_wr_idx, a_win_full);
      end
      n_checks++;
      if (a_out_cnt !== 16'd0) begin
         n_errors++;
         $display("FAIL reset_out_cnt: got %0d want 0", a_out_cnt);
      end
      n_checks++;
      if (u_dut.r_state !== IDLE) begin
         n_errors++;
         $display("FAIL reset_state: got %0d want IDLE", u_dut.r_state);
      end
      a_reset = 1'b0; a_in_valid = 1'b0;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 9; i++) begin
         a_in_valid = 1'b1;
         #1;
         n_checks++;
         if ({a_dp_wr_en, a_dp_wr_idx, a_dp_compute, a_win_full} !== {1'b1, 4'(i), (i == 8), 1'b0}) begin
            n_errors++;
            $display("FAIL fill_%0d: got en=%b idx=%0d cmp=%b wf=%b want 1/%0d/%b/0",
                     i, a_dp_wr_en, a_dp_wr_idx, a_dp_compute, a_win_full, i, (i == 8));
         end
         if (a_dp_compute) n_issue++;
         cyc();
      end
      n_checks++;
      if ({a_out_valid, a_win_full} !== 2'b11 || u_dut.r_state !== RUN) begin
         n_errors++;
         $display("FAIL fill_done: got ov=%b wf=%b st=%0d want 1/1/RUN", a_out_valid, a_win_full, u_dut.r_state);
      end
   endtask

   task automatic test_continuous();
      for (int i = 9; i < 20; i++) begin
         a_in_valid = 1'b1;
         #1;
         n_checks++;
         if ({a_dp_wr_idx, a_dp_compute, a_out_valid} !== {4'(i % 9), 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL cont_%0d: got idx=%0d cmp=%b ov=%b want %0d/1/1",
                     i, a_dp_wr_idx, a_dp_compute, a_out_valid, i % 9);
         end
         if (a_dp_compute) n_issue++;
         cyc();
      end
      a_in_valid = 1'b0;
      cyc();
      n_checks++;
      if (n_issue !== 12) begin
         n_errors++;
         $display("FAIL cont_issues: got %0d want 12", n_issue);
      end
      n_checks++;
      if (a_out_cnt !== 16'd12 || a_out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL cont_out_cnt: got cnt=%0d ov=%b want 12/0", a_out_cnt, a_out_valid);
      end
   endtask

   task automatic test_stall();
      a_in_valid = 1'b1;
      #1;
      n_checks++;
      if ({a_dp_wr_idx, a_dp_compute} !== {4'd2, 1'b1}) begin
         n_errors++;
         $display("FAIL stall_pre: got idx=%0d cmp=%b want 2/1", a_dp_wr_idx, a_dp_compute);
      end
      cyc();
      a_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if ({a_dp_stall, a_in_ready, a_dp_wr_en, a_dp_compute, a_out_valid, a_dp_wr_idx} !==
             {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3}) begin
            n_errors++;
            $display("FAIL stall_%0d: got st=%b rdy=%b en=%b cmp=%b ov=%b idx=%0d want 1/0/0/0/1/3",
                     i, a_dp_stall, a_in_ready, a_dp_wr_en, a_dp_compute, a_out_valid, a_dp_wr_idx);
         end
         cyc();
      end
      n_checks++;
      if (a_out_cnt !== 16'd12) begin
         n_errors++;
         $display("FAIL stall_cnt_hold: got %0d want 12", a_out_cnt);
      end
      a_out_ready = 1'b1;
      #1;
      n_checks++;
      if ({a_dp_stall, a_dp_wr_en, a_dp_wr_idx} !== {1'b0, 1'b1, 4'd3}) begin
         n_errors++;
         $display("FAIL stall_resume: got st=%b en=%b idx=%0d want 0/1/3", a_dp_stall, a_dp_wr_en, a_dp_wr_idx);
      end
      cyc();
      n_checks++;
      if (a_out_cnt !== 16'd13 || a_out_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL stall_drain1: got cnt=%0d ov=%b want 13/1", a_out_cnt, a_out_valid);
      end
      a_in_valid = 1'b0;
      cyc();
      n_checks++;
      if (a_out_cnt !== 16'd14 || a_out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL stall_drain2: got cnt=%0d ov=%b want 14/0", a_out_cnt, a_out_valid);
      end
   endtask

   task automatic test_gap();
      int acc;
      acc = 0;
      a_reset = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b1;
      cyc();
      a_reset = 1'b0;
      for (int c = 0; c < 17; c++) begin
         a_in_valid = (c % 2 == 0);
         #1;
         n_checks++;
         if ({a_dp_wr_en, a_dp_wr_idx, a_dp_compute, a_out_valid} !== {a_in_valid, 4'(acc), (c == 16), 1'b0}) begin
            n_errors++;
            $display("FAIL gap_%0d: got en=%b idx=%0d cmp=%b ov=%b want %b/%0d/%b/0",
                     c, a_dp_wr_en, a_dp_wr_idx, a_dp_compute, a_out_valid, a_in_valid, acc, (c == 16));
         end
         if (a_in_valid) acc++;
         cyc();
      end
      n_checks++;
      if ({a_out_valid, a_win_full} !== 2'b11) begin
         n_errors++;
         $display("FAIL gap_first_y: got ov=%b wf=%b want 1/1", a_out_valid, a_win_full);
      end
      a_in_valid = 1'b0;
      cyc();
      n_checks++;
      if (a_out_cnt !== 16'd1) begin
         n_errors++;
         $display("FAIL gap_out_cnt: got %0d want 1", a_out_cnt);
      end
   endtask

   task automatic test_reset_midop();
      a_reset = 1'b1;
      cyc();
      a_reset = 1'b0;
      a_in_valid = 1'b1;
      for (int i = 0; i < 15; i++) cyc();
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_cnt !== 16'd6) begin
         n_errors++;
         $display("FAIL midop_pre: got ov=%b cnt=%0d want 1/6", a_out_valid, a_out_cnt);
      end
      a_reset = 1'b1; a_out_ready = 1'b0;
      #1;
      n_checks++;
      if ({a_in_ready, a_dp_stall, a_dp_wr_en} !== 3'b000) begin
         n_errors++;
         $display("FAIL midop_reset_comb: got rdy=%b st=%b en=%b want 0/0/0", a_in_ready, a_dp_stall, a_dp_wr_en);
      end
      cyc();
      n_checks++;
      if ({a_out_valid, a_win_full, a_dp_wr_idx} !== 6'b0 || a_out_cnt !== 16'd0 || u_dut.r_state !== IDLE) begin
         n_errors++;
         $display("FAIL midop_reset_regs: got ov=%b wf=%b idx=%0d cnt=%0d st=%0d want 0/0/0/0/IDLE",
                  a_out_valid, a_win_full, a_dp_wr_idx, a_out_cnt, u_dut.r_state);
      end
      a_reset = 1'b0; a_out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         a_in_valid = 1'b1;
         #1;
         n_checks++;
         if ({a_dp_compute, a_out_valid, a_dp_wr_idx} !== {(i == 8), 1'b0, 4'(i)}) begin
            n_errors++;
            $display("FAIL midop_refill_%0d: got cmp=%b ov=%b idx=%0d want %b/0/%0d",
                     i, a_dp_compute, a_out_valid, a_dp_wr_idx, (i == 8), i);
         end
         cyc();
      end
      a_in_valid = 1'b0;
      n_checks++;
      if (a_out_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL midop_first_y: got %b want 1", a_out_valid);
      end
      cyc();
      n_checks++;
      if (a_out_cnt !== 16'd1) begin
         n_errors++;
         $display("FAIL midop_out_cnt: got %0d want 1", a_out_cnt);
      end
   endtask

   task automatic test_latency_wrap();
      b_reset = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b1;
      cyc();
      b_reset = 1'b0;
      for (int k = 1; k <= 28; k++) begin
         b_in_valid = (k <= 25);
         cyc();
         n_checks++;
         if (b_out_valid !== (k >= 11 && k <= 27)) begin
            n_errors++;
            $display("FAIL lat3_ov_%0d: got %b want %b", k, b_out_valid, (k >= 11 && k <= 27));
         end
         if (k == 26) begin
            n_checks++;
            if (b_out_cnt !== 4'd15) begin
               n_errors++;
               $display("FAIL lat3_cnt_pre_wrap: got %0d want 15", b_out_cnt);
            end
         end
      end
      n_checks++;
      if (b_out_cnt !== 4'd1 || b_dp_wr_idx !== 4'd7) begin
         n_errors++;
         $display("FAIL lat3_wrap: got cnt=%0d idx=%0d want 1/7", b_out_cnt, b_dp_wr_idx);
      end
   endtask

`ifdef CS_FLUSH_EN
   task automatic test_flush();
      b_in_valid = 1'b1;
      cyc(); cyc();
      b_flush = 1'b1;
      #1;
      n_checks++;
      if ({b_in_ready, b_dp_wr_en, b_dp_compute} !== 3'b000) begin
         n_errors++;
         $display("FAIL flush_comb: got rdy=%b en=%b cmp=%b want 0/0/0", b_in_ready, b_dp_wr_en, b_dp_compute);
      end
      cyc();
      b_flush = 1'b0; b_in_valid = 1'b0;
      n_checks++;
      if ({b_out_valid, b_win_full, b_dp_wr_idx} !== 6'b0 || b_out_cnt !== 4'd1) begin
         n_errors++;
         $display("FAIL flush_regs: got ov=%b wf=%b idx=%0d cnt=%0d want 0/0/0/1",
                  b_out_valid, b_win_full, b_dp_wr_idx, b_out_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_checks++;
         if (b_out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_no_y_%0d: got %b want 0", i, b_out_valid);
         end
      end
      for (int i = 0; i < 9; i++) begin
         b_in_valid = 1'b1;
         #1;
         n_checks++;
         if ({b_dp_compute, b_dp_wr_idx} !== {(i == 8), 4'(i)}) begin
            n_errors++;
            $display("FAIL flush_refill_%0d: got cmp=%b idx=%0d want %b/%0d", i, b_dp_compute, b_dp_wr_idx, (i == 8), i);
         end
         cyc();
      end
      b_in_valid = 1'b0;
      cyc(); cyc();
      n_checks++;
      if (b_out_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL flush_first_y: got %b want 1", b_out_valid);
      end
      cyc();
      n_checks++;
      if (b_out_cnt !== 4'd2) begin
         n_errors++;
         $display("FAIL flush_out_cnt: got %0d want 2", b_out_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_continuous();
      test_stall();
      test_gap();
      test_reset_midop();
      test_latency_wrap();
`ifdef CS_FLUSH_EN
      test_flush();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
